baud_gen_frac: RTL
==================

// Module: baud_gen_frac
// PURPOSE
//  Fractional-N baud tick generator for the UART TX/RX paths. Emits an oversample tick
//  (os_tick) whose average period is div_int + div_frac/2^FRAC_W clocks, plus derived
//  bit-rate (bit_tick) and mid-bit (mid_tick) strobes. Divisor is runtime-reprogrammable
//  via a valid/ready handshake; restart re-aligns phase to an RX start-bit edge.
// PARAMETERS
//  CLK_FREQ    100_000_000  input clock frequency, Hz
//  BAUD_RATE   9600         baud rate used for the reset-default divisor
//  OVERSAMPLE  16           os_ticks per bit; power of two, 4..64
//  INT_W       16           width of integer divisor part
//  FRAC_W      4            width of fractional divisor part (units of 1/2^FRAC_W)
//  DEF_INT     CLK_FREQ/(BAUD_RATE*OVERSAMPLE)                    (derived localparam)
//  DEF_FRAC    round(rem*2^FRAC_W/(BAUD_RATE*OVERSAMPLE)), rem = CLK_FREQ mod (BAUD_RATE*OVERSAMPLE)
// PORTS
//  clk          in   1               clock
//  rst          in   1               asynchronous reset, active-high
//  en           in   1               count enable; 0 freezes all state
//  restart      in   1               sync restart: zero cnt/acc/phase
//  cfg_valid    in   1               new divisor offered
//  cfg_ready    out  1               generator can accept a divisor
//  cfg_div_int  in   INT_W           new integer divisor
//  cfg_div_frac in   FRAC_W          new fractional divisor
//  os_tick      out  1               1-cycle oversample strobe
//  mid_tick     out  1               1-cycle strobe at os_phase -> OVERSAMPLE/2
//  bit_tick     out  1               1-cycle strobe at os_phase -> 0 (bit boundary)
//  os_phase     out  $clog2(OVERSAMPLE)  os_ticks since last bit boundary
// BEHAVIOUR
//  - Reset: os_tick=mid_tick=bit_tick=0, os_phase=0, cfg_ready=1, cnt=0, acc=0, no pending cfg,
//    active divisor = {DEF_INT, DEF_FRAC}. All outputs registered.
//  - Period rule: {c_k, acc_k} = acc_(k-1) + div_frac (FRAC_W+1 bit sum), acc_(-1)=0;
//    period k length L_k = div_int + c_k clocks. Effective div_int < 2 is clamped to 2.
//  - cnt counts 0..L_k-1 while en=1; on cnt==L_k-1: cnt<=0, os_tick<=1 next cycle, acc updates.
//    First os_tick is asserted L_0 enabled edges after reset release / restart.
//  - os_phase increments mod OVERSAMPLE on each os_tick; bit_tick coincident with the os_tick
//    that wraps os_phase to 0; mid_tick coincident with the os_tick setting it to OVERSAMPLE/2.
//  - en=0: cnt, acc, os_phase hold; strobes forced 0; resumes exactly where frozen.
//  - restart=1 (priority over en and terminal count): cnt, acc, os_phase <= 0, strobes 0 that
//    cycle; pending cfg applied immediately. Next os_tick L_0 enabled edges after restart drops.
//  - cfg handshake: transfer when cfg_valid && cfg_ready; value captured to pending reg,
//    cfg_ready<=0 next cycle. Pending applied (glitch-free) at the terminal-count cycle: the new
//    divisor governs the following period and acc<=0; or immediately if en=0 or restart=1.
//    cfg_ready returns 1 the cycle after apply. cfg_valid while cfg_ready=0 is ignored.
//  - Simultaneous transfer and terminal count: value is captured, applied at the next boundary.
//  - Wrap: acc wraps mod 2^FRAC_W by construction; os_phase wraps mod OVERSAMPLE.
//  - Reset mid-operation: immediate return to reset state, pending cfg discarded.
// TESTING
//  - Defaults (100MHz, 9600, x16): DEF_INT=651, DEF_FRAC=1; 16 os_tick periods = 651*15+652 clocks.
//  - cfg {54,4} (115200): os_tick periods repeat 54,54,54,55; bit_tick every 868 clocks exactly.
//  - cfg {10,0}: all periods 10; os_phase 0..15; mid_tick at phase 8, bit_tick at phase 0.
//  - en low 37 cycles mid-period: no strobes; after en high, tick arrives exactly 37 clocks late.
//  - restart pulse at cnt=5 with pending cfg {20,0}: phase=0, next os_tick 20 clocks later, cfg_ready=1.
//  - cfg {0,0} and {1,8}: periods clamp to 2 (and 2/3 alternating); rst mid-period -> reset values.

Source files
------------

// File: rtl/baud_gen_frac.sv
// Fractional-N baud tick generator: os/mid/bit strobes, average os period div_int + div_frac/2^FRAC_W clocks.
// Divisor reloads through valid/ready at period boundaries; restart re-aligns phase to an RX start edge.
module baud_gen_frac #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16,
  parameter int INT_W      = 16,
  parameter int FRAC_W     = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          en,
  input  logic                          restart,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [INT_W-1:0]              cfg_div_int,
  input  logic [FRAC_W-1:0]             cfg_div_frac,
  output logic                          os_tick,
  output logic                          mid_tick,
  output logic                          bit_tick,
  output logic [$clog2(OVERSAMPLE)-1:0] os_phase
);

  localparam int     PH_W   = $clog2(OVERSAMPLE);
  localparam int     DIVR   = BAUD_RATE * OVERSAMPLE;
  localparam int     REM    = CLK_FREQ % DIVR;
  // Rounded fraction; a round-up to a whole unit carries into the integer part.
  localparam longint FRAC_R = ((longint'(REM) << (FRAC_W + 1)) + longint'(DIVR)) / (2 * longint'(DIVR));
  localparam logic [INT_W-1:0]  DEF_INT  = INT_W'(longint'(CLK_FREQ / DIVR) + (FRAC_R >> FRAC_W));
  localparam logic [FRAC_W-1:0] DEF_FRAC = FRAC_W'(FRAC_R);
  localparam logic [PH_W-1:0]   MID_PH   = PH_W'(OVERSAMPLE / 2);

  logic [INT_W-1:0]  div_int, pend_int, cnt, eff_int;
  logic [FRAC_W-1:0] div_frac, pend_frac, acc;
  logic              pend_vld;
  logic [FRAC_W:0]   acc_sum;
  logic [INT_W:0]    last_cnt;
  logic              term, apply;
  logic [PH_W-1:0]   phase_nxt;

  always_comb begin
    acc_sum   = {1'b0, acc} + {1'b0, div_frac};
    eff_int   = (div_int < INT_W'(2)) ? INT_W'(2) : div_int;
    last_cnt  = {1'b0, eff_int} + {{INT_W{1'b0}}, acc_sum[FRAC_W]} - (INT_W+1)'(1);
    // >= rather than == so a shorter divisor loaded while frozen cannot strand cnt past the end.
    term      = ({1'b0, cnt} >= last_cnt);
    apply     = pend_vld && (restart || !en || term);
    phase_nxt = os_phase + PH_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt       <= '0;
      acc       <= '0;
      os_phase  <= '0;
      os_tick   <= 1'b0;
      mid_tick  <= 1'b0;
      bit_tick  <= 1'b0;
      div_int   <= DEF_INT;
      div_frac  <= DEF_FRAC;
      pend_vld  <= 1'b0;
      pend_int  <= '0;
      pend_frac <= '0;
      cfg_ready <= 1'b1;
    end else begin
      os_tick  <= 1'b0;
      mid_tick <= 1'b0;
      bit_tick <= 1'b0;
      if (restart) begin
        cnt      <= '0;
        acc      <= '0;
        os_phase <= '0;
      end else if (en) begin
        if (term) begin
          cnt      <= '0;
          acc      <= acc_sum[FRAC_W-1:0];
          os_tick  <= 1'b1;
          os_phase <= phase_nxt;
          mid_tick <= (phase_nxt == MID_PH);
          bit_tick <= (phase_nxt == '0);
        end else begin
          cnt <= cnt + INT_W'(1);
        end
      end
      if (cfg_valid && cfg_ready) begin
        pend_int  <= cfg_div_int;
        pend_frac <= cfg_div_frac;
        pend_vld  <= 1'b1;
        cfg_ready <= 1'b0;
      end
      // New divisor starts a fresh fractional sequence.
      if (apply) begin
        div_int   <= pend_int;
        div_frac  <= pend_frac;
        acc       <= '0;
        pend_vld  <= 1'b0;
        cfg_ready <= 1'b1;
      end
    end
  end

endmodule
